bellek_erisim_birimi: RTL and testbench

Load/store access unit sitting directly upstream of the word-wide main memory (anabellek).
- Accepts RISC-V byte/halfword/word load and store requests from the core's memory stage over a valid/ready handshake.
- Drives the memory's combinational-read / synchronous-write port.
- Sub-word stores use read-modify-write; loads are extracted and sign- or zero-extended.
- Returns one response per request, with an error flag for misaligned, out-of-range or illegal accesses.

---
 rtl/bellek_erisim_pkg.sv | 36 +++
 rtl/bellek_erisim_birimi_veri_hizalayici.sv | 45 ++++
 rtl/bellek_erisim_birimi.sv | 139 +++++++++++++
 tb/tb_bellek_erisim_birimi.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bellek_erisim_pkg.sv
// Shared types and constants for the load/store access unit.
package bellek_erisim_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YAZ   = 2'd2,
        YANIT = 2'd3
    } durum_t;

    // RISC-V funct3 encodings for loads/stores
    localparam logic [2:0] TIP_B  = 3'b000;
    localparam logic [2:0] TIP_H  = 3'b001;
    localparam logic [2:0] TIP_W  = 3'b010;
    localparam logic [2:0] TIP_BU = 3'b100;
    localparam logic [2:0] TIP_HU = 3'b101;

    // Stores only come in B/H/W; loads additionally have the unsigned forms.
    function automatic logic tip_gecersiz(input logic yaz, input logic [2:0] tip);
        if (yaz) begin
            return !(tip == TIP_B || tip == TIP_H || tip == TIP_W);
        end
        return !(tip == TIP_B || tip == TIP_H || tip == TIP_W ||
                 tip == TIP_BU || tip == TIP_HU);
    endfunction

    // Natural alignment by access size, taken from funct3[1:0].
    function automatic logic hizasiz(input logic [2:0] tip, input logic [1:0] adres_dusuk);
        case (tip[1:0])
            2'b01:   return adres_dusuk[0];
            2'b10:   return |adres_dusuk;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bellek_erisim_birimi_veri_hizalayici.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module veri_hizalayici
    import bellek_erisim_pkg::*;
(
    input  logic [31:0] kelime_i,
    input  logic [1:0]  bayt_sec_i,
    input  logic [2:0]  tip_i,
    input  logic [31:0] yaz_veri_i,
    output logic [31:0] yukle_veri_o,
    output logic [31:0] birlesik_kelime_o
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    // Pick the addressed lane and sign/zero extend it for loads.
    always_comb begin
        bayt  = kelime_i[{bayt_sec_i, 3'b000} +: 8];
        yarim = bayt_sec_i[1] ? kelime_i[31:16] : kelime_i[15:0];
        case (tip_i)
            TIP_B:   yukle_veri_o = {{24{bayt[7]}}, bayt};
            TIP_BU:  yukle_veri_o = {24'h0, bayt};
            TIP_H:   yukle_veri_o = {{16{yarim[15]}}, yarim};
            TIP_HU:  yukle_veri_o = {16'h0, yarim};
            default: yukle_veri_o = kelime_i;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane.
    always_comb begin
        birlesik_kelime_o = kelime_i;
        case (tip_i[1:0])
            2'b00: birlesik_kelime_o[{bayt_sec_i, 3'b000} +: 8] = yaz_veri_i[7:0];
            2'b01: begin
                if (bayt_sec_i[1]) begin
                    birlesik_kelime_o[31:16] = yaz_veri_i[15:0];
                end else begin
                    birlesik_kelime_o[15:0] = yaz_veri_i[15:0];
                end
            end
            default: birlesik_kelime_o = yaz_veri_i;
        endcase
    end

endmodule

// File: rtl/bellek_erisim_birimi.sv
// Load/store access unit in front of the word-wide main memory.
module bellek_erisim_birimi
    import bellek_erisim_pkg::*;
#(
    parameter int unsigned             ADRES_BIT       = 32,
    parameter logic [ADRES_BIT-1:0]    BASLANGIC_ADRES = 32'h8000_0000,
    parameter int unsigned             BELLEK_SATIR    = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 istek_gecerli,
    output logic                 istek_hazir,
    input  logic                 istek_yaz,
    input  logic [2:0]           istek_tip,
    input  logic [ADRES_BIT-1:0] istek_adres,
    input  logic [31:0]          istek_veri,
    output logic                 yanit_gecerli,
    input  logic                 yanit_hazir,
    output logic [31:0]          yanit_veri,
    output logic                 yanit_hata,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [31:0]          bellek_oku_veri,
    output logic [31:0]          bellek_yaz_veri,
    output logic                 bellek_yaz_gecerli
);

    durum_t               durum_q, durum_d;
    logic [1:0]           bayt_sec_q, bayt_sec_d;
    logic [2:0]           tip_q, tip_d;
    logic                 yaz_q, yaz_d;
    // Holds the raw store data after acceptance, then the merged word after OKU.
    logic [31:0]          yaz_kelime_q, yaz_kelime_d;
    logic [31:0]          yanit_veri_q, yanit_veri_d;
    logic                 yanit_hata_q, yanit_hata_d;
    logic [ADRES_BIT-1:0] bellek_adres_q, bellek_adres_d;

    logic [ADRES_BIT-1:0] ofset;
    logic                 hata;
    logic [31:0]          yukle_veri;
    logic [31:0]          birlesik_kelime;

    veri_hizalayici u_hizalayici (
        .kelime_i          (bellek_oku_veri),
        .bayt_sec_i        (bayt_sec_q),
        .tip_i             (tip_q),
        .yaz_veri_i        (yaz_kelime_q),
        .yukle_veri_o      (yukle_veri),
        .birlesik_kelime_o (birlesik_kelime)
    );

    // Acceptance-time error check: illegal type, misalignment, or outside the window.
    always_comb begin
        ofset = istek_adres - BASLANGIC_ADRES;
        hata  = tip_gecersiz(istek_yaz, istek_tip) ||
                hizasiz(istek_tip, istek_adres[1:0]) ||
                (ofset >= ADRES_BIT'(BELLEK_SATIR));
    end

    // Next-state and datapath updates for the access FSM.
    always_comb begin
        durum_d        = durum_q;
        bayt_sec_d     = bayt_sec_q;
        tip_d          = tip_q;
        yaz_d          = yaz_q;
        yaz_kelime_d   = yaz_kelime_q;
        yanit_veri_d   = yanit_veri_q;
        yanit_hata_d   = yanit_hata_q;
        bellek_adres_d = bellek_adres_q;
        case (durum_q)
            BOSTA: begin
                if (istek_gecerli) begin
                    bayt_sec_d   = istek_adres[1:0];
                    tip_d        = istek_tip;
                    yaz_d        = istek_yaz;
                    yaz_kelime_d = istek_veri;
                    yanit_veri_d = '0;
                    yanit_hata_d = 1'b0;
                    if (hata) begin
                        yanit_hata_d = 1'b1;
                        durum_d      = YANIT;
                    end else begin
                        // Memory address is only refreshed for real memory cycles.
                        bellek_adres_d = {istek_adres[ADRES_BIT-1:2], 2'b00};
                        durum_d = (istek_yaz && istek_tip == TIP_W) ? YAZ : OKU;
                    end
                end
            end
            OKU: begin
                if (yaz_q) begin
                    yaz_kelime_d = birlesik_kelime;
                    durum_d      = YAZ;
                end else begin
                    yanit_veri_d = yukle_veri;
                    durum_d      = YANIT;
                end
            end
            YAZ: durum_d = YANIT;
            YANIT: begin
                if (yanit_hazir) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // State and latch registers; reset aborts whatever access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q        <= BOSTA;
            bayt_sec_q     <= '0;
            tip_q          <= '0;
            yaz_q          <= 1'b0;
            yaz_kelime_q   <= '0;
            yanit_veri_q   <= '0;
            yanit_hata_q   <= 1'b0;
            bellek_adres_q <= '0;
        end else begin
            durum_q        <= durum_d;
            bayt_sec_q     <= bayt_sec_d;
            tip_q          <= tip_d;
            yaz_q          <= yaz_d;
            yaz_kelime_q   <= yaz_kelime_d;
            yanit_veri_q   <= yanit_veri_d;
            yanit_hata_q   <= yanit_hata_d;
            bellek_adres_q <= bellek_adres_d;
        end
    end

    assign istek_hazir        = !rst && (durum_q == BOSTA);
    assign yanit_gecerli      = (durum_q == YANIT);
    assign yanit_veri         = yanit_veri_q;
    assign yanit_hata         = yanit_hata_q;
    assign bellek_adres       = bellek_adres_q;
    assign bellek_yaz_veri    = yaz_kelime_q;
    // Write enable follows the state so an async reset in YAZ drops it at once.
    assign bellek_yaz_gecerli = (durum_q == YAZ);

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// Bench for the load/store access unit with a word-array model of main memory.
module tb_bellek_erisim_birimi;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic        istek_yaz = 1'b0;
    logic [2:0]  istek_tip = 3'b000;
    logic [31:0] istek_adres = '0;
    logic [31:0] istek_veri = '0;
    logic        yanit_gecerli;
    logic        yanit_hazir = 1'b0;
    logic [31:0] yanit_veri;
    logic        yanit_hata;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_oku_veri;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz_gecerli;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_sayac = 0;

    // Expected behaviour of the current transaction
    logic [31:0] exp_veri;
    logic        exp_hata;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wr_adr;
    logic [31:0] exp_wr_dat;

    logic [31:0] model_mem [int];
    logic [31:0] mem [0:511];
    logic [31:0] got_veri;
    logic        got_hata;

    bellek_erisim_birimi #(
        .ADRES_BIT       (32),
        .BASLANGIC_ADRES (BASE),
        .BELLEK_SATIR    (2048)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .istek_gecerli      (istek_gecerli),
        .istek_hazir        (istek_hazir),
        .istek_yaz          (istek_yaz),
        .istek_tip          (istek_tip),
        .istek_adres        (istek_adres),
        .istek_veri         (istek_veri),
        .yanit_gecerli      (yanit_gecerli),
        .yanit_hazir        (yanit_hazir),
        .yanit_veri         (yanit_veri),
        .yanit_hata         (yanit_hata),
        .bellek_adres       (bellek_adres),
        .bellek_oku_veri    (bellek_oku_veri),
        .bellek_yaz_veri    (bellek_yaz_veri),
        .bellek_yaz_gecerli (bellek_yaz_gecerli)
    );

    always #5 clk = ~clk;

    // Main memory: combinational read, synchronous write
    logic [31:0] mem_ofs;
    always_comb begin
        mem_ofs = bellek_adres - BASE;
        bellek_oku_veri = (mem_ofs < 32'd2048) ? mem[mem_ofs[10:2]] : 32'h0;
    end
    always @(posedge clk) begin
        if (bellek_yaz_gecerli && mem_ofs < 32'd2048) mem[mem_ofs[10:2]] <= bellek_yaz_veri;
    end

    task automatic kontrol(input string ad, input logic [31:0] act, input logic [31:0] beklenen);
        n_assert++;
        if (act !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", ad, act, beklenen, $time);
        end
    endtask

    // Reference behaviour from the access rules: size, alignment, window, lane arithmetic
    task automatic model_hesap(input logic yaz, input logic [2:0] tip,
                               input logic [31:0] adr, input logic [31:0] dat);
        int          boy;
        int          kaydir;
        logic        gecerli_tip;
        logic [31:0] kelime, ham, maske;
        int          k;
        if (yaz) gecerli_tip = (tip <= 3'd2);
        else     gecerli_tip = (tip <= 3'd2) || (tip == 3'd4) || (tip == 3'd5);
        boy = 1 << tip[1:0];
        exp_hata = !gecerli_tip || (adr % boy != 0) || (adr < BASE) || (adr >= BASE + 32'd2048);
        k = int'((adr - BASE) >> 2);
        kelime = model_mem.exists(k) ? model_mem[k] : 32'h0;
        kaydir = int'(adr % 4) * 8;
        ham = kelime >> kaydir;
        maske = (boy == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * boy)) - 32'h1);
        exp_veri = 32'h0;
        exp_wr = 0;
        exp_lat = 0;
        exp_wr_adr = adr & ~32'h3;
        exp_wr_dat = 32'h0;
        if (!exp_hata) begin
            if (!yaz) begin
                exp_veri = ham & maske;
                if (!tip[2] && boy < 4 && ham[8 * boy - 1]) exp_veri = exp_veri | ~maske;
                exp_lat = 1;
            end else begin
                exp_wr = 1;
                exp_wr_dat = (kelime & ~(maske << kaydir)) | ((dat & maske) << kaydir);
                exp_lat = (boy == 4) ? 1 : 2;
            end
        end
    endtask

    // Per-cycle compare of response and memory-write outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (yanit_gecerli) begin
                kontrol("yanit_veri", yanit_veri, exp_veri);
                kontrol("yanit_hata", 32'(yanit_hata), 32'(exp_hata));
            end
            if (bellek_yaz_gecerli) begin
                wr_sayac++;
                kontrol("yaz_adres", bellek_adres, exp_wr_adr);
                kontrol("yaz_veri", bellek_yaz_veri, exp_wr_dat);
            end
        end
    end

    task automatic istek(input logic yaz, input logic [2:0] tip, input logic [31:0] adr,
                         input logic [31:0] dat, input int bekle);
        int n;
        int lat;
        int wr_bas;
        model_hesap(yaz, tip, adr, dat);
        wr_bas = wr_sayac;
        n = 0;
        @(negedge clk);
        while (!istek_hazir && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!istek_hazir) begin
            kontrol("istek_hazir_zaman_asimi", 32'(istek_hazir), 32'd1);
            return;
        end
        istek_gecerli = 1'b1;
        istek_yaz = yaz;
        istek_tip = tip;
        istek_adres = adr;
        istek_veri = dat;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        lat = 0;
        while (!yanit_gecerli && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        kontrol("gecikme", 32'(lat), 32'(exp_lat));
        got_veri = yanit_veri;
        got_hata = yanit_hata;
        if (!yanit_gecerli) return;
        for (int i = 0; i < bekle; i++) begin
            @(negedge clk);
            kontrol("bekle_istek_hazir", 32'(istek_hazir), 32'd0);
            kontrol("bekle_yanit_gecerli", 32'(yanit_gecerli), 32'd1);
        end
        @(negedge clk);
        yanit_hazir = 1'b1;
        @(posedge clk);
        #1;
        yanit_hazir = 1'b0;
        kontrol("el_sikisma_gecerli", 32'(yanit_gecerli), 32'd0);
        kontrol("el_sikisma_hazir", 32'(istek_hazir), 32'd1);
        kontrol("yazma_sayisi", 32'(wr_sayac - wr_bas), 32'(exp_wr));
        if (exp_wr == 1) model_mem[int'((adr - BASE) >> 2)] = exp_wr_dat;
    endtask

    initial begin
        #200000;
        $display("FAIL global_zaman_asimi: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int wr_bas;
        // Reset state
        @(negedge clk);
        kontrol("rst_istek_hazir", 32'(istek_hazir), 32'd0);
        kontrol("rst_yanit_gecerli", 32'(yanit_gecerli), 32'd0);
        kontrol("rst_yaz_gecerli", 32'(bellek_yaz_gecerli), 32'd0);
        kontrol("rst_bellek_adres", bellek_adres, 32'h0);
        kontrol("rst_yanit_veri", yanit_veri, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        kontrol("rst_sonrasi_hazir", 32'(istek_hazir), 32'd1);

        // Word store then load
        istek(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 0);
        istek(1'b0, 3'b010, 32'h8000_0010, 32'h0, 0);
        kontrol("lw_literal", got_veri, 32'hDEAD_BEEF);

        // Byte store via read-modify-write, then sub-word loads
        istek(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00AA, 0);
        istek(1'b0, 3'b000, 32'h8000_0013, 32'h0, 0);
        kontrol("lb_literal", got_veri, 32'hFFFF_FFAA);
        istek(1'b0, 3'b100, 32'h8000_0013, 32'h0, 0);
        kontrol("lbu_literal", got_veri, 32'h0000_00AA);
        istek(1'b0, 3'b001, 32'h8000_0012, 32'h0, 0);
        kontrol("lh_literal", got_veri, 32'hFFFF_AAAD);
        istek(1'b0, 3'b010, 32'h8000_0010, 32'h0, 0);
        kontrol("lw_birlesik_literal", got_veri, 32'hAAAD_BEEF);

        // Halfword store into the upper lane
        istek(1'b1, 3'b010, 32'h8000_0014, 32'h1122_3344, 0);
        istek(1'b1, 3'b001, 32'h8000_0016, 32'h0000_BEEF, 0);
        istek(1'b0, 3'b101, 32'h8000_0016, 32'h0, 0);
        kontrol("lhu_literal", got_veri, 32'h0000_BEEF);
        istek(1'b0, 3'b000, 32'h8000_0014, 32'h0, 0);
        kontrol("lb_lane0_literal", got_veri, 32'h0000_0044);

        // Last word of the window
        istek(1'b1, 3'b010, 32'h8000_07FC, 32'hCAFE_F00D, 0);
        istek(1'b0, 3'b010, 32'h8000_07FC, 32'h0, 0);
        kontrol("sinir_lw_literal", got_veri, 32'hCAFE_F00D);

        // Error cases
        istek(1'b0, 3'b010, 32'h8000_0002, 32'h0, 0);
        kontrol("hizasiz_lw_hata", 32'(got_hata), 32'd1);
        istek(1'b1, 3'b010, 32'h7FFF_FFFC, 32'h1234_5678, 0);
        kontrol("alt_sinir_sw_hata", 32'(got_hata), 32'd1);
        istek(1'b0, 3'b011, 32'h8000_0010, 32'h0, 0);
        kontrol("tip011_hata", 32'(got_hata), 32'd1);
        istek(1'b0, 3'b001, 32'h8000_0011, 32'h0, 0);
        istek(1'b1, 3'b000, 32'h8000_0800, 32'h55, 0);
        kontrol("ust_sinir_sb_hata", 32'(got_hata), 32'd1);
        istek(1'b1, 3'b100, 32'h8000_0010, 32'h55, 0);

        // Stalled response stays stable
        istek(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5);
        istek(1'b0, 3'b000, 32'h8000_0010, 32'h0, 0);
        kontrol("arka_arkaya_lb_literal", got_veri, 32'hFFFF_FFEF);

        // Reset during the write cycle of a halfword store
        istek(1'b1, 3'b010, 32'h8000_0020, 32'h1234_5678, 0);
        model_hesap(1'b1, 3'b001, 32'h8000_0020, 32'h0000_ABCD);
        wr_bas = wr_sayac;
        @(negedge clk);
        istek_gecerli = 1'b1;
        istek_yaz = 1'b1;
        istek_tip = 3'b001;
        istek_adres = 32'h8000_0020;
        istek_veri = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        istek_gecerli = 1'b0;
        @(posedge clk);
        #1;
        kontrol("yaz_dongusunde", 32'(bellek_yaz_gecerli), 32'd1);
        rst = 1'b1;
        #1;
        kontrol("rst_yaz_dusuk", 32'(bellek_yaz_gecerli), 32'd0);
        kontrol("rst_hazir_dusuk", 32'(istek_hazir), 32'd0);
        kontrol("rst_gecerli_dusuk", 32'(yanit_gecerli), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        kontrol("rst_yazma_yok", 32'(wr_sayac - wr_bas), 32'd0);
        @(posedge clk);
        #1;
        kontrol("rst_birakma_hazir", 32'(istek_hazir), 32'd1);
        istek(1'b0, 3'b010, 32'h8000_0020, 32'h0, 0);
        kontrol("rst_eski_deger_literal", got_veri, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
